// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - circular return-address stack with recursion counters and checkpoint/restore
module ras_ckpt #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 30,
   parameter int CTR_W  = 2,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] push_addr_i,
   output logic [ADDR_W-1:0] top_o,
   output logic              top_valid_o,
   output logic [CNT_W-1:0]  count_o,
   output logic [PTR_W-1:0]  ckpt_ptr_o,
   output logic [ADDR_W-1:0] ckpt_top_o,
   output logic [CTR_W-1:0]  ckpt_ctr_o,
   output logic [CNT_W-1:0]  ckpt_cnt_o,
   input  logic              restore_i,
   input  logic [PTR_W-1:0]  restore_ptr_i,
   input  logic [ADDR_W-1:0] restore_top_i,
   input  logic [CTR_W-1:0]  restore_ctr_i,
   input  logic [CNT_W-1:0]  restore_cnt_i
);

   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] stk [DEPTH];
   logic [CTR_W-1:0]  ctr [DEPTH];
   logic [PTR_W-1:0]  tp;
   logic [CNT_W-1:0]  cnt;

   logic [ADDR_W-1:0] top_entry;
   logic [CTR_W-1:0]  top_ctr;
   logic              non_empty;
   logic [PTR_W-1:0]  tp_inc;
   logic [PTR_W-1:0]  tp_dec;

   logic              stk_we;
   logic [PTR_W-1:0]  stk_idx;
   logic [ADDR_W-1:0] stk_val;
   logic              ctr_we;
   logic [PTR_W-1:0]  ctr_idx;
   logic [CTR_W-1:0]  ctr_val;
   logic [PTR_W-1:0]  tp_nxt;
   logic [CNT_W-1:0]  cnt_nxt;

   assign top_entry = stk[tp];
   assign top_ctr   = ctr[tp];
   assign non_empty = (cnt != '0);
   assign tp_inc    = tp + PTR_W'(1);
   assign tp_dec    = tp - PTR_W'(1);

   always_comb begin
      stk_we  = 1'b0;
      stk_idx = tp;
      stk_val = push_addr_i;
      ctr_we  = 1'b0;
      ctr_idx = tp;
      ctr_val = '0;
      tp_nxt  = tp;
      cnt_nxt = cnt;
      if (restore_i) begin
         stk_we  = 1'b1;
         stk_idx = restore_ptr_i;
         stk_val = restore_top_i;
         ctr_we  = 1'b1;
         ctr_idx = restore_ptr_i;
         ctr_val = restore_ctr_i;
         tp_nxt  = restore_ptr_i;
         cnt_nxt = restore_cnt_i;
      end else if (push_i && pop_i && non_empty) begin
         // call+return in one cycle replaces the top in place
         stk_we  = 1'b1;
         ctr_we  = 1'b1;
         ctr_val = '0;
      end else if (push_i) begin
         if (non_empty && push_addr_i == top_entry && top_ctr != CTR_MAX) begin
            ctr_we  = 1'b1;
            ctr_val = top_ctr + CTR_W'(1);
         end else begin
            // at full occupancy the slot at tp+1 is the oldest entry and is overwritten
            stk_we  = 1'b1;
            stk_idx = tp_inc;
            ctr_we  = 1'b1;
            ctr_idx = tp_inc;
            ctr_val = '0;
            tp_nxt  = tp_inc;
            cnt_nxt = (cnt == CNT_FULL) ? cnt : cnt + CNT_W'(1);
         end
      end else if (pop_i && non_empty) begin
         if (top_ctr != '0) begin
            ctr_we  = 1'b1;
            ctr_val = top_ctr - CTR_W'(1);
         end else begin
            tp_nxt  = tp_dec;
            cnt_nxt = cnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tp  <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ctr[i] <= '0;
         end
      end else begin
         tp  <= tp_nxt;
         cnt <= cnt_nxt;
         if (ctr_we) begin
            ctr[ctr_idx] <= ctr_val;
         end
      end
   end

   // address storage carries no reset; reset only blocks writes
   always_ff @(posedge clk) begin
      if (rst_n && stk_we) begin
         stk[stk_idx] <= stk_val;
      end
   end

   assign top_valid_o = non_empty;
   assign top_o       = non_empty ? top_entry : '0;
   assign count_o     = cnt;
   assign ckpt_ptr_o  = tp;
   assign ckpt_top_o  = top_entry;
   assign ckpt_ctr_o  = top_ctr;
   assign ckpt_cnt_o  = cnt;

endmodule

// File: tb/tb_ras_ckpt.sv
// tb/tb_ras_ckpt.sv - directed self-checking bench for ras_ckpt (DEPTH=4, CTR_W=2)
module tb_ras_ckpt;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 30;
   localparam int CTR_W  = 2;
   localparam int PTR_W  = 2;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              push_i;
   logic              pop_i;
   logic [ADDR_W-1:0] push_addr_i;
   logic [ADDR_W-1:0] top_o;
   logic              top_valid_o;
   logic [CNT_W-1:0]  count_o;
   logic [PTR_W-1:0]  ckpt_ptr_o;
   logic [ADDR_W-1:0] ckpt_top_o;
   logic [CTR_W-1:0]  ckpt_ctr_o;
   logic [CNT_W-1:0]  ckpt_cnt_o;
   logic              restore_i;
   logic [PTR_W-1:0]  restore_ptr_i;
   logic [ADDR_W-1:0] restore_top_i;
   logic [CTR_W-1:0]  restore_ctr_i;
   logic [CNT_W-1:0]  restore_cnt_i;

   int tests = 0;
   int fails = 0;

   ras_ckpt #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CTR_W(CTR_W)) dut (
      .clk(clk), .rst_n(rst_n), .push_i(push_i), .pop_i(pop_i),
      .push_addr_i(push_addr_i), .top_o(top_o), .top_valid_o(top_valid_o),
      .count_o(count_o), .ckpt_ptr_o(ckpt_ptr_o), .ckpt_top_o(ckpt_top_o),
      .ckpt_ctr_o(ckpt_ctr_o), .ckpt_cnt_o(ckpt_cnt_o), .restore_i(restore_i),
      .restore_ptr_i(restore_ptr_i), .restore_top_i(restore_top_i),
      .restore_ctr_i(restore_ctr_i), .restore_cnt_i(restore_cnt_i)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic p, input logic q, input logic [ADDR_W-1:0] a);
      push_i = p;
      pop_i = q;
      push_addr_i = a;
      @(posedge clk);
      #1;
      push_i = 1'b0;
      pop_i = 1'b0;
      restore_i = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, '0);
   endtask

   task automatic test_reset();
      do_reset();
      cyc(1'b1, 1'b0, 30'h11);
      cyc(1'b1, 1'b0, 30'h22);
      rst_n = 1'b0;
      cyc(1'b1, 1'b0, 30'h33);
      tests++; if (top_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %0d want 0", top_valid_o); end
      tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count_o); end
      tests++; if (top_o !== 30'h0) begin fails++; $display("FAIL reset_top got %h want 0", top_o); end
      tests++; if (ckpt_ptr_o !== 2'd0) begin fails++; $display("FAIL reset_ptr got %0d want 0", ckpt_ptr_o); end
      cyc(1'b0, 1'b1, '0);
      tests++; if (count_o !== 3'd0 || top_valid_o !== 1'b0 || top_o !== 30'h0)
         begin fails++; $display("FAIL pop_empty got cnt=%0d v=%0d top=%h want 0/0/0", count_o, top_valid_o, top_o); end
   endtask

   task automatic test_push_pop();
      do_reset();
      cyc(1'b1, 1'b0, 30'h100);
      tests++; if (top_o !== 30'h100 || count_o !== 3'd1)
         begin fails++; $display("FAIL push_latency got top=%h cnt=%0d want 100/1", top_o, count_o); end
      cyc(1'b1, 1'b0, 30'h200);
      cyc(1'b1, 1'b0, 30'h300);
      tests++; if (top_o !== 30'h300 || count_o !== 3'd3)
         begin fails++; $display("FAIL push3 got top=%h cnt=%0d want 300/3", top_o, count_o); end
      cyc(1'b0, 1'b1, '0);
      tests++; if (top_o !== 30'h200 || count_o !== 3'd2)
         begin fails++; $display("FAIL pop1 got top=%h cnt=%0d want 200/2", top_o, count_o); end
   endtask

   task automatic test_overflow();
      logic [ADDR_W-1:0] exp_top [4];
      exp_top[0] = 30'd4; exp_top[1] = 30'd3; exp_top[2] = 30'd2; exp_top[3] = 30'd0;
      do_reset();
      for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, ADDR_W'(i));
      tests++; if (count_o !== 3'd4 || top_o !== 30'd5 || ckpt_ptr_o !== 2'd1)
         begin fails++; $display("FAIL overflow got cnt=%0d top=%h ptr=%0d want 4/5/1", count_o, top_o, ckpt_ptr_o); end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, '0);
         tests++; if (top_o !== exp_top[i] || count_o !== CNT_W'(3 - i))
            begin fails++; $display("FAIL overflow_pop%0d got top=%h cnt=%0d want %h/%0d", i, top_o, count_o, exp_top[i], 3 - i); end
      end
      tests++; if (top_valid_o !== 1'b0) begin fails++; $display("FAIL overflow_empty got %0d want 0", top_valid_o); end
   endtask

   task automatic test_recursion();
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 30'h100);
      tests++; if (count_o !== 3'd1 || ckpt_ctr_o !== 2'd2)
         begin fails++; $display("FAIL rec_push got cnt=%0d ctr=%0d want 1/2", count_o, ckpt_ctr_o); end
      cyc(1'b0, 1'b1, '0);
      cyc(1'b0, 1'b1, '0);
      tests++; if (top_o !== 30'h100 || count_o !== 3'd1 || ckpt_ctr_o !== 2'd0)
         begin fails++; $display("FAIL rec_pop2 got top=%h cnt=%0d ctr=%0d want 100/1/0", top_o, count_o, ckpt_ctr_o); end
      cyc(1'b0, 1'b1, '0);
      tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL rec_pop3 got %0d want 0", count_o); end
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 30'h100);
      tests++; if (count_o !== 3'd2 || ckpt_ctr_o !== 2'd0 || top_o !== 30'h100)
         begin fails++; $display("FAIL rec_sat got cnt=%0d ctr=%0d top=%h want 2/0/100", count_o, ckpt_ctr_o, top_o); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      cyc(1'b1, 1'b0, 30'hA);
      cyc(1'b1, 1'b0, 30'hA);
      cyc(1'b1, 1'b1, 30'hD);
      tests++; if (top_o !== 30'hD || count_o !== 3'd1 || ckpt_ctr_o !== 2'd0)
         begin fails++; $display("FAIL callret got top=%h cnt=%0d ctr=%0d want d/1/0", top_o, count_o, ckpt_ctr_o); end
      do_reset();
      cyc(1'b1, 1'b1, 30'hD);
      tests++; if (top_o !== 30'hD || count_o !== 3'd1)
         begin fails++; $display("FAIL callret_empty got top=%h cnt=%0d want d/1", top_o, count_o); end
   endtask

   task automatic test_restore();
      logic [PTR_W-1:0]  s_ptr;
      logic [ADDR_W-1:0] s_top;
      logic [CTR_W-1:0]  s_ctr;
      logic [CNT_W-1:0]  s_cnt;
      do_reset();
      cyc(1'b1, 1'b0, 30'hA);
      cyc(1'b1, 1'b0, 30'hB);
      s_ptr = ckpt_ptr_o; s_top = ckpt_top_o; s_ctr = ckpt_ctr_o; s_cnt = ckpt_cnt_o;
      tests++; if (s_ptr !== 2'd2 || s_top !== 30'hB || s_ctr !== 2'd0 || s_cnt !== 3'd2)
         begin fails++; $display("FAIL ckpt got ptr=%0d top=%h ctr=%0d cnt=%0d want 2/b/0/2", s_ptr, s_top, s_ctr, s_cnt); end
      cyc(1'b1, 1'b0, 30'hC);
      cyc(1'b0, 1'b1, '0);
      cyc(1'b0, 1'b1, '0);
      cyc(1'b1, 1'b0, 30'hE);
      tests++; if (top_o !== 30'hE || count_o !== 3'd2)
         begin fails++; $display("FAIL wrong_path got top=%h cnt=%0d want e/2", top_o, count_o); end
      restore_i = 1'b1; restore_ptr_i = s_ptr; restore_top_i = s_top;
      restore_ctr_i = s_ctr; restore_cnt_i = s_cnt;
      cyc(1'b1, 1'b0, 30'hF);
      tests++; if (top_o !== 30'hB || count_o !== 3'd2)
         begin fails++; $display("FAIL restore got top=%h cnt=%0d want b/2", top_o, count_o); end
      cyc(1'b0, 1'b1, '0);
      tests++; if (top_o !== 30'hA || count_o !== 3'd1)
         begin fails++; $display("FAIL restore_pop got top=%h cnt=%0d want a/1", top_o, count_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      cyc(1'b1, 1'b0, 30'h5);
      // reset must win over a simultaneous restore
      rst_n = 1'b0;
      restore_i = 1'b1; restore_ptr_i = 2'd3; restore_top_i = 30'h77;
      restore_ctr_i = 2'd1; restore_cnt_i = 3'd3;
      cyc(1'b0, 1'b0, '0);
      tests++; if (count_o !== 3'd0 || ckpt_ptr_o !== 2'd0)
         begin fails++; $display("FAIL rst_over_restore got cnt=%0d ptr=%0d want 0/0", count_o, ckpt_ptr_o); end
      restore_i = 1'b1;
      cyc(1'b0, 1'b1, '0);
      tests++; if (top_o !== 30'h77 || count_o !== 3'd3 || ckpt_ctr_o !== 2'd1 || ckpt_ptr_o !== 2'd3)
         begin fails++; $display("FAIL restore_pop_ignored got top=%h cnt=%0d ctr=%0d ptr=%0d want 77/3/1/3", top_o, count_o, ckpt_ctr_o, ckpt_ptr_o); end
      cyc(1'b0, 1'b1, '0);
      tests++; if (top_o !== 30'h77 || count_o !== 3'd3 || ckpt_ctr_o !== 2'd0)
         begin fails++; $display("FAIL restored_ctr_pop got top=%h cnt=%0d ctr=%0d want 77/3/0", top_o, count_o, ckpt_ctr_o); end
   endtask

   initial begin
      rst_n = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0;
      restore_i = 1'b0; restore_ptr_i = '0; restore_top_i = '0;
      restore_ctr_i = '0; restore_cnt_i = '0;
      @(negedge clk);
      test_reset();
      test_push_pop();
      test_overflow();
      test_recursion();
      test_same_cycle();
      test_restore();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
